cursor_position_tracker: RTL
============================

Name: cursor_position_tracker

Overview:
- Sits directly upstream of the cursor sprite renderer and produces its sprite_x/sprite_y top-left coordinates from mouse movement reports.
- Accumulates signed deltas with screen clamping and republishes the position only at frame start, so the sprite never tears mid-frame.
- Also produces click pulses and a 4-bit idle-fade alpha for the cursor transparency fade in the compositor.

Parameters:
SCREEN_W, 640, visible width in pixels
SCREEN_H, 480, visible height in pixels
SPRITE_W, 64, cursor sprite width; max x = SCREEN_W-SPRITE_W
SPRITE_H, 64, cursor sprite height; max y = SCREEN_H-SPRITE_H
SPEED_SHIFT, 0, deltas are multiplied by 2^SPEED_SHIFT before accumulation
IDLE_FRAMES, 120, frames without activity before fading starts
FADE_FRAMES, 4, frames per alpha decrement once fading (must be >=1)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse at start of vertical blank
rpt_valid  in  1  mouse report valid
rpt_ready  out  1  block can accept a report
rpt_dx  in  9  signed two's-complement x delta, positive = right
rpt_dy  in  9  signed two's-complement y delta, positive = up
rpt_buttons  in  3  [0] left, [1] right, [2] middle, 1 = pressed
sprite_x  out  10  latched sprite top-left x
sprite_y  out  9  latched sprite top-left y
alpha  out  4  cursor opacity, 15 = opaque, 0 = invisible
left_click  out  1  one-cycle pulse on left-button press
right_click  out  1  one-cycle pulse on right-button press
buttons_held  out  3  last accepted button state

Behaviour:
- Reset (async, reset_n=0):
  - acc_x = sprite_x = (SCREEN_W-SPRITE_W)/2 = 288; acc_y = sprite_y = (SCREEN_H-SPRITE_H)/2 = 208.
  - alpha = 15; idle_cnt = fade_cnt = 0; moved_pending = 0.
  - left_click = right_click = 0; buttons_held = 0; FSM = IDLE; rpt_ready = 1.
  - Reset mid-APPLY discards the captured report.
- FSM IDLE: rpt_ready = 1. On rpt_valid & rpt_ready, capture dx/dy/buttons and go to APPLY.
- FSM APPLY (one cycle): rpt_ready = 0.
  - Sign-extend deltas to 12 bits, then shift left by SPEED_SHIFT.
  - nx = acc_x + dx_s, clamped to [0, SCREEN_W-SPRITE_W].
  - ny = acc_y - dy_s, clamped to [0, SCREEN_H-SPRITE_H].
  - Clamp uses signed 12-bit compare, so no wrap-around is possible.
  - Write acc_x/acc_y and buttons_held <= captured buttons.
  - left_click = captured[0] & ~buttons_held[0]; right_click likewise for bit [1]. Both are registered and asserted for exactly this cycle.
  - Activity = (dx != 0) | (dy != 0) | any newly pressed button. Activity sets moved_pending.
  - Return to IDLE.
- Throughput: one report per 2 cycles. Handshake at edge N → acc valid after edge N+1.
- Frame latch: on a clk edge with frame_start = 1, sprite_x/sprite_y <= current registered acc_x/acc_y.
  - An APPLY in the same cycle as frame_start is not visible until the next frame_start.
- Fade (evaluated only on frame_start):
  - If moved_pending: alpha <= 15, idle_cnt <= 0, fade_cnt <= 0, clear moved_pending.
  - Else if idle_cnt < IDLE_FRAMES: idle_cnt++.
  - Else: fade_cnt++. When fade_cnt == FADE_FRAMES-1, wrap fade_cnt to 0 and decrement alpha, saturating at 0.
  - First decrement therefore occurs on idle frame IDLE_FRAMES+FADE_FRAMES.
  - If APPLY sets moved_pending in the same cycle that frame_start clears it, set wins.
- Outputs are all registered; no combinational path from rpt_* to any output.

Test Plan:
1. After reset release, observe outputs → sprite_x=288, sprite_y=208, alpha=15, rpt_ready=1. Send report dx=+10, dy=+5, then pulse frame_start → sprite_x=298, sprite_y=203.
2. Clamp: send dx=+255 three times, dy=-256 twice, then frame_start → sprite_x=576, sprite_y=416. Then dx=-256 three times, dy=+255 twice, then frame_start → sprite_x=0, sprite_y=0.
3. Latch timing: with rpt_valid held high, report accepted every 2nd cycle (rpt_ready 1,0,1,0). Report dx=+4 whose APPLY cycle coincides with frame_start → sprite_x unchanged that frame; +4 appears at the next frame_start.
4. Clicks: buttons 000→001→001→011→000 → left_click pulses once (2nd report), right_click pulses once (4th report), buttons_held=000 at end, no other pulses.
5. Fade with IDLE_FRAMES=2, FADE_FRAMES=2, no reports: alpha stays 15 through 3 frame_starts, 14 after the 4th, 0 after the 32nd and stays 0. Then a report with dx=+1 followed by frame_start → alpha=15.
6. Reset mid-APPLY (reset_n low during APPLY cycle, report dx=+50) → after release sprite_x=288, no click pulse, FSM in IDLE with rpt_ready=1.

Source files
------------

// File: rtl/cursor_position_tracker.sv
// Cursor position tracker: accumulates clamped mouse deltas, republishes the
// sprite position only at frame start, and generates click pulses plus an
// idle-fade alpha for the compositor.
module cursor_position_tracker #(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int SPRITE_W    = 64,
  parameter int SPRITE_H    = 64,
  parameter int SPEED_SHIFT = 0,
  parameter int IDLE_FRAMES = 120,
  parameter int FADE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_start,
  input  logic       rpt_valid,
  output logic       rpt_ready,
  input  logic [8:0] rpt_dx,
  input  logic [8:0] rpt_dy,
  input  logic [2:0] rpt_buttons,
  output logic [9:0] sprite_x,
  output logic [8:0] sprite_y,
  output logic [3:0] alpha,
  output logic       left_click,
  output logic       right_click,
  output logic [2:0] buttons_held
);

  localparam int MAX_X = SCREEN_W - SPRITE_W;
  localparam int MAX_Y = SCREEN_H - SPRITE_H;
  localparam logic [9:0] INIT_X = 10'(MAX_X / 2);
  localparam logic [8:0] INIT_Y = 9'(MAX_Y / 2);
  localparam logic [9:0] MAX_X_V = 10'(MAX_X);
  localparam logic [8:0] MAX_Y_V = 9'(MAX_Y);
  localparam logic signed [11:0] MAX_X_S = 12'(MAX_X);
  localparam logic signed [11:0] MAX_Y_S = 12'(MAX_Y);
  localparam int IDLE_W = (IDLE_FRAMES < 1) ? 1 : $clog2(IDLE_FRAMES + 1);
  localparam int FADE_W = (FADE_FRAMES < 2) ? 1 : $clog2(FADE_FRAMES);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(IDLE_FRAMES);
  localparam logic [FADE_W-1:0] FADE_LAST  = FADE_W'(FADE_FRAMES - 1);

  typedef enum logic {ST_IDLE, ST_APPLY} state_t;

  state_t r_state;
  state_t w_nextState;

  logic              r_ready;
  logic [8:0]        r_capDx;
  logic [8:0]        r_capDy;
  logic [2:0]        r_capBtn;
  logic [9:0]        r_accX;
  logic [8:0]        r_accY;
  logic [9:0]        r_spriteX;
  logic [8:0]        r_spriteY;
  logic [3:0]        r_alpha;
  logic [IDLE_W-1:0] r_idleCnt;
  logic [FADE_W-1:0] r_fadeCnt;
  logic              r_movedPending;
  logic              r_leftClick;
  logic              r_rightClick;
  logic [2:0]        r_btnHeld;

  logic              w_accept;
  logic              w_apply;
  logic              w_activity;
  logic [2:0]        w_newPress;
  logic signed [11:0] w_dxS;
  logic signed [11:0] w_dyS;
  logic signed [11:0] w_nx;
  logic signed [11:0] w_ny;
  logic [9:0]        w_clampX;
  logic [8:0]        w_clampY;

  assign w_accept   = rpt_valid && (r_state == ST_IDLE);
  assign w_apply    = (r_state == ST_APPLY);
  assign w_newPress = r_capBtn & ~r_btnHeld;
  assign w_activity = (r_capDx != 9'd0) || (r_capDy != 9'd0) || (w_newPress != 3'b000);

  // Deltas are sign-extended before scaling so negative moves stay negative
  assign w_dxS = $signed({{3{r_capDx[8]}}, r_capDx}) <<< SPEED_SHIFT;
  assign w_dyS = $signed({{3{r_capDy[8]}}, r_capDy}) <<< SPEED_SHIFT;
  // Screen y grows downward while the mouse reports positive = up
  assign w_nx  = $signed({2'b00, r_accX}) + w_dxS;
  assign w_ny  = $signed({3'b000, r_accY}) - w_dyS;

  // State register for the accept/apply handshake FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_nextState;
      r_ready <= (w_nextState == ST_IDLE);
    end
  end

  // Next-state logic: accept one report, spend exactly one cycle applying it
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_nextState = ST_APPLY;
      ST_APPLY: w_nextState = ST_IDLE;
      default:  w_nextState = ST_IDLE;
    endcase
  end

  // Signed clamp of the candidate position into the visible sprite range
  always_comb begin
    w_clampX = w_nx[9:0];
    w_clampY = w_ny[8:0];
    if (w_nx < 12'sd0) begin
      w_clampX = 10'd0;
    end else if (w_nx > MAX_X_S) begin
      w_clampX = MAX_X_V;
    end
    if (w_ny < 12'sd0) begin
      w_clampY = 9'd0;
    end else if (w_ny > MAX_Y_S) begin
      w_clampY = MAX_Y_V;
    end
  end

  // Capture the report fields on the handshake
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_capDx  <= 9'd0;
      r_capDy  <= 9'd0;
      r_capBtn <= 3'b000;
    end else if (w_accept) begin
      r_capDx  <= rpt_dx;
      r_capDy  <= rpt_dy;
      r_capBtn <= rpt_buttons;
    end
  end

  // Apply cycle: update accumulator, button state and one-cycle click pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_accX       <= INIT_X;
      r_accY       <= INIT_Y;
      r_btnHeld    <= 3'b000;
      r_leftClick  <= 1'b0;
      r_rightClick <= 1'b0;
    end else begin
      r_leftClick  <= 1'b0;
      r_rightClick <= 1'b0;
      if (w_apply) begin
        r_accX       <= w_clampX;
        r_accY       <= w_clampY;
        r_btnHeld    <= r_capBtn;
        r_leftClick  <= w_newPress[0];
        r_rightClick <= w_newPress[1];
      end
    end
  end

  // Publish the accumulated position only at frame start to avoid tearing
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_spriteX <= INIT_X;
      r_spriteY <= INIT_Y;
    end else if (frame_start) begin
      r_spriteX <= r_accX;
      r_spriteY <= r_accY;
    end
  end

  // Activity flag: a new apply sets it even on the frame that consumes it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_movedPending <= 1'b0;
    end else if (w_apply && w_activity) begin
      r_movedPending <= 1'b1;
    end else if (frame_start) begin
      r_movedPending <= 1'b0;
    end
  end

  // Per-frame idle counting and stepped alpha fade
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_alpha   <= 4'hF;
      r_idleCnt <= '0;
      r_fadeCnt <= '0;
    end else if (frame_start) begin
      if (r_movedPending) begin
        r_alpha   <= 4'hF;
        r_idleCnt <= '0;
        r_fadeCnt <= '0;
      end else if (r_idleCnt < IDLE_LIMIT) begin
        r_idleCnt <= r_idleCnt + 1'b1;
      end else if (r_fadeCnt == FADE_LAST) begin
        r_fadeCnt <= '0;
        r_alpha   <= (r_alpha == 4'h0) ? 4'h0 : r_alpha - 4'h1;
      end else begin
        r_fadeCnt <= r_fadeCnt + 1'b1;
      end
    end
  end

  assign rpt_ready    = r_ready;
  assign sprite_x     = r_spriteX;
  assign sprite_y     = r_spriteY;
  assign alpha        = r_alpha;
  assign left_click   = r_leftClick;
  assign right_click  = r_rightClick;
  assign buttons_held = r_btnHeld;

endmodule
